// File: rtl/io_pattern_engine.sv
// Pad-level bring-up engine for the user I/O ring.
// Generates counter, walking-one and PRBS patterns, or loops the bidirectional bus back and checks its PRBS stream.
module io_pattern_engine #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] step_div,
    input  logic             chk_clr,
    input  logic [WIDTH-1:0] bi_in,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] bi_out,
    output logic [WIDTH-1:0] bi_oe,
    output logic             lock,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        MODE_CNT  = 2'b00,
        MODE_WALK = 2'b01,
        MODE_PRBS = 2'b10,
        MODE_LOOP = 2'b11
    } mode_e;

    localparam int CW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] prescCnt_q, prescCnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] walk_q, walk_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic [WIDTH-1:0] biOut_q, biOut_d;
    logic [WIDTH-1:0] biOe_q, biOe_d;
    logic [1:0]       modeSeen_q, modeSeen_d;
    logic [WIDTH-1:0] prevSample_q, prevSample_d;
    logic             seeded_q, seeded_d;
    logic             lock_q, lock_d;
    logic             armed_q, armed_d;
    logic [2:0]       matchRun_q, matchRun_d;
    logic [2:0]       missRun_q, missRun_d;
    logic [7:0]       errCount_q, errCount_d;
    logic             tick;
    logic             modeChanged;
    mode_e            modeSel;

    // An all-zero state would lock the LFSR up, so it is forced back to 1.
    function automatic logic [WIDTH-1:0] lfsrStep(input logic [WIDTH-1:0] s);
        if (s == '0) begin
            return ONE_W;
        end
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    assign modeSel = mode_e'(mode);
    assign tick    = en && (prescCnt_q == step_div);

    always_comb begin
        prescCnt_d = prescCnt_q;
        cnt_d      = cnt_q;
        walk_d     = walk_q;
        lfsr_d     = lfsr_q;
        if (en) begin
            prescCnt_d = tick ? '0 : prescCnt_q + DIV_W'(1);
        end
        if (tick) begin
            cnt_d  = cnt_q + CW'(1);
            walk_d = {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
            lfsr_d = lfsrStep(lfsr_q);
        end
    end

    always_comb begin
        outData_d = outData_q;
        biOut_d   = biOut_q;
        biOe_d    = biOe_q;
        if (en) begin
            case (modeSel)
                MODE_CNT: begin
                    outData_d = cnt_q[WIDTH-1:0];
                    biOut_d   = cnt_q[CW-1:WIDTH];
                    biOe_d    = '1;
                end
                MODE_WALK: begin
                    outData_d = walk_q;
                    biOut_d   = ~walk_q;
                    biOe_d    = '1;
                end
                MODE_PRBS: begin
                    outData_d = lfsr_q;
                    biOut_d   = lfsr_q;
                    biOe_d    = '1;
                end
                default: begin
                    outData_d = bi_in;
                    biOut_d   = '0;
                    biOe_d    = '0;
                end
            endcase
        end
    end

    // A mode change resets the checker; a tick on that same edge in loopback becomes the seed sample.
    always_comb begin
        modeChanged  = en && (mode != modeSeen_q);
        modeSeen_d   = en ? mode : modeSeen_q;
        prevSample_d = prevSample_q;
        seeded_d     = seeded_q;
        lock_d       = lock_q;
        armed_d      = armed_q;
        matchRun_d   = matchRun_q;
        missRun_d    = missRun_q;
        errCount_d   = errCount_q;
        if (modeChanged) begin
            seeded_d   = 1'b0;
            lock_d     = 1'b0;
            armed_d    = 1'b0;
            matchRun_d = '0;
            missRun_d  = '0;
        end
        if (tick && (modeSel == MODE_LOOP)) begin
            prevSample_d = bi_in;
            if (!seeded_d) begin
                seeded_d = 1'b1;
            end else if ((bi_in != '0) && (bi_in == lfsrStep(prevSample_q))) begin
                missRun_d = '0;
                if (matchRun_d != 3'd4) begin
                    matchRun_d = matchRun_d + 3'd1;
                end
                if (matchRun_d == 3'd4) begin
                    lock_d  = 1'b1;
                    armed_d = 1'b1;
                end
            end else begin
                matchRun_d = '0;
                if (missRun_d != 3'd4) begin
                    missRun_d = missRun_d + 3'd1;
                end
                if (missRun_d == 3'd4) begin
                    lock_d = 1'b0;
                end
                if (armed_d && (errCount_q != 8'hFF)) begin
                    errCount_d = errCount_q + 8'd1;
                end
            end
        end
        if (en && chk_clr) begin
            errCount_d = '0;
            armed_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescCnt_q   <= '0;
            cnt_q        <= '0;
            walk_q       <= ONE_W;
            lfsr_q       <= ONE_W;
            outData_q    <= '0;
            biOut_q      <= '0;
            biOe_q       <= '0;
            modeSeen_q   <= '0;
            prevSample_q <= '0;
            seeded_q     <= 1'b0;
            lock_q       <= 1'b0;
            armed_q      <= 1'b0;
            matchRun_q   <= '0;
            missRun_q    <= '0;
            errCount_q   <= '0;
        end else begin
            prescCnt_q   <= prescCnt_d;
            cnt_q        <= cnt_d;
            walk_q       <= walk_d;
            lfsr_q       <= lfsr_d;
            outData_q    <= outData_d;
            biOut_q      <= biOut_d;
            biOe_q       <= biOe_d;
            modeSeen_q   <= modeSeen_d;
            prevSample_q <= prevSample_d;
            seeded_q     <= seeded_d;
            lock_q       <= lock_d;
            armed_q      <= armed_d;
            matchRun_q   <= matchRun_d;
            missRun_q    <= missRun_d;
            errCount_q   <= errCount_d;
        end
    end

    assign out_data  = outData_q;
    assign bi_out    = biOut_q;
    assign bi_oe     = biOe_q;
    assign lock      = lock_q;
    assign err_count = errCount_q;

endmodule

// File: doc/io_pattern_engine.md
# io_pattern_engine

Parametrised pattern generator and loopback checker for pad-level bring-up of the user I/O ring. It drives a dedicated output bus and a bidirectional bus with selectable patterns: counter, walking-one or PRBS. In loopback mode it releases the bidirectional bus, echoes it to the output bus and checks the incoming stream for PRBS integrity. It sits between the top-level pin wrapper and the pads, and replaces the fixed 8-bit counter/loopback test block.

## Interface
Parameters:
- WIDTH, 8, width of each I/O bus; the internal counter is 2*WIDTH bits.
- TAPS, 8'hB8, Galois LFSR feedback mask, WIDTH bits.
- DIV_W, 8, width of the step prescaler.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  global enable; 0 freezes all state and outputs.
- mode  in  2  00 counter, 01 walking-one, 10 PRBS generate, 11 loopback/check.
- step_div  in  DIV_W  pattern advances once every step_div+1 enabled cycles.
- chk_clr  in  1  clears err_count and the armed flag.
- bi_in  in  WIDTH  bidirectional bus input path.
- out_data  out  WIDTH  dedicated output bus.
- bi_out  out  WIDTH  bidirectional bus output path.
- bi_oe  out  WIDTH  bidirectional bus enable; 1 = drive.
- lock  out  1  checker locked to the PRBS stream.
- err_count  out  8  saturating mismatch count.

## Operation
- Reset state (rst=1 at a clock edge): out_data=0, bi_out=0, bi_oe=0, lock=0, err_count=0, cnt=0, walk=1, lfsr=1, prescaler=0, match_run=0, miss_run=0, armed=0. rst has priority over en.
- Prescaler: counts 0..step_div while en=1. tick=1 when prescaler==step_div, and the prescaler then returns to 0. With step_div=0, tick=1 every cycle.
- On each tick, all generators advance regardless of mode:
  - cnt increments and wraps 2^(2*WIDTH)-1 -> 0.
  - walk rotates left; MSB wraps to bit 0.
  - lfsr steps: next=(s>>1)^(s[0]?TAPS:0). A state of 0 reloads 1.
- Output register, loaded on every enabled cycle from the current mode and state:
  - 00: out_data=cnt[WIDTH-1:0], bi_out=cnt[2*WIDTH-1:WIDTH], bi_oe=all 1.
  - 01: out_data=walk, bi_out=~walk, bi_oe=all 1.
  - 10: out_data=lfsr, bi_out=lfsr, bi_oe=all 1.
  - 11: out_data=bi_in, bi_out=0, bi_oe=0.
- Checker, active in mode 11 only, samples bi_in on ticks. Expected value = lfsr_step(previous sample); the checker is self-synchronising.
  - A sample of 0 always counts as a mismatch.
  - The first sample after mode entry only seeds the checker; it is not compared.
  - Match: match_run++ (saturates at 4) and miss_run=0. lock sets when match_run reaches 4. armed sets with lock.
  - Mismatch: miss_run++ and match_run=0. lock clears when miss_run reaches 4. err_count++ if armed, saturating at 255.
  - chk_clr=1: err_count=0 and armed=0. chk_clr beats a simultaneous increment.
  - Any mode change: lock, match_run, miss_run, armed and the seed flag all clear. err_count is held.
- en=0: prescaler, generators, checker and outputs all hold.

## Timing
- Generator state updates on the tick edge. out_data and bi_out show the new value one cycle later.
- A mode change is visible on the outputs at the next enabled edge, with 1-cycle latency. bi_oe switches on that same edge.
- Loopback echo: out_data equals bi_in registered once, with 1-cycle latency.
- lock and err_count update on the tick edge of the deciding sample.
- A single corrupted word in a valid stream produces 2 mismatches: the bad word, and the next word compared against the bad word's successor. lock is kept.
- rst asserted mid-operation returns every register to its reset value at the next edge, with no residual output.

## Test plan
- rst, then mode=00, step_div=0, en=1 -> out_data 00,01,02… one per cycle starting on the 2nd cycle. bi_out becomes 01 after 256 ticks. After 65536 ticks cnt wraps and both buses read 00.
- mode=01, step_div=2 -> out_data 01,02,04…80,01, each value held 3 cycles. bi_out=FE,FD,…; bi_oe=FF throughout.
- mode=10, step_div=0 from reset -> out_data 01,B8,5C,2E,17,B3…. Period is 255 and 00 never appears.
- mode=11 with bi_in driven by the model PRBS -> out_data echoes bi_in 1 cycle later and bi_oe=00. lock rises on the 5th sampled word (1 seed + 4 matches) and err_count=0. Corrupting one word gives err_count=2 with lock still 1.
- After lock, drive bi_in=00 for 300 ticks -> lock falls after the 4th mismatch and err_count saturates at 255. Pulsing chk_clr together with a mismatch leaves err_count=0.
- en=0 for 10 cycles mid-stream -> all outputs frozen, then resume from the same state. rst mid-stream in mode 10 -> the next cycle shows all outputs 0 and lfsr restarts at 01.
